// File: rtl/cbm2_segment.sv
// 6509-style segment generator: execution/indirect segment registers at $0000/$0001,
// (zp),Y cycle tracking, and the per-cycle segment that prefixes the CPU address.
module cbm2_segment (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_en,
  input  logic [15:0] cpuAddr,
  input  logic        cpuWe,
  input  logic        cpuSync,
  input  logic [7:0]  cpuDo,
  input  logic [7:0]  busDi,
  output logic [7:0]  cpuDi,
  output logic [7:0]  cpuSeg,
  output logic [3:0]  execSeg,
  output logic [3:0]  indSeg,
  output logic        regAccess
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    IND1 = 3'd4,
    IND2 = 3'd5
  } state_t;

  state_t     state;
  logic [3:0] exec_reg;
  logic [3:0] ind_reg;
  logic       in_ind;

  // Only LDA (zp),Y and STA (zp),Y reach into the indirect segment.
  function automatic logic is_ind_opcode(input logic [7:0] op);
    return (op == 8'hB1) || (op == 8'h91);
  endfunction

  assign regAccess = (cpuAddr[15:1] == 15'd0);
  assign execSeg   = exec_reg;
  assign indSeg    = ind_reg;
  assign in_ind    = (state == IND1) || (state == IND2);

  always_comb begin
    cpuDi = busDi;
    if (regAccess)
      cpuDi = cpuAddr[0] ? {4'h0, ind_reg} : {4'h0, exec_reg};
  end

  // An opcode fetch always runs from the execution segment, which also ends a
  // non-page-crossing $B1 right after IND1.
  always_comb begin
    cpuSeg = {4'h0, exec_reg};
    if (in_ind && !cpuSync)
      cpuSeg = {4'h0, ind_reg};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      exec_reg <= 4'hF;
      ind_reg  <= 4'hF;
    end else if (cpu_en) begin
      if (cpuWe && regAccess) begin
        if (cpuAddr[0])
          ind_reg  <= cpuDo[3:0];
        else
          exec_reg <= cpuDo[3:0];
      end

      if (cpuSync) begin
        state <= is_ind_opcode(cpuDi) ? T1 : IDLE;
      end else begin
        // A write during the operand/pointer cycles can only be an interrupt push.
        case (state)
          T1:      state <= cpuWe ? IDLE : T2;
          T2:      state <= cpuWe ? IDLE : T3;
          T3:      state <= cpuWe ? IDLE : IND1;
          IND1:    state <= IND2;
          IND2:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
